// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-bank completer.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_slv_state_t;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x WIDTH register array: synchronous clear, one write port, one combinational read port.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage update: clear wins over a same-cycle write so a reset never leaves a partial write.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a bank of DEPTH registers and WAIT_CYCLES wait states per access.
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             pselect,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [WIDTH-1:0] paddr,
    input  logic [WIDTH-1:0] pwdata,
    output logic [WIDTH-1:0] prdata,
    output logic             pready,
    output logic             pslverr
);

    localparam int IDX_W = $clog2(DEPTH);
    // One extra bit so DEPTH == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0] DEPTH_V = (WIDTH + 1)'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    apb_slv_state_t          state_r;
    logic [WAIT_CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]        addr_r;
    logic [WIDTH-1:0]        wdata_r;
    logic                    write_r;
    logic [WIDTH-1:0]        prdata_r;
    logic                    pready_r;
    logic                    pslverr_r;

    logic                    in_range_s;
    logic                    exec_s;
    logic                    we_s;
    logic [WIDTH-1:0]        rdata_s;

    assign in_range_s = ({1'b0, addr_r} < DEPTH_V);
    assign exec_s     = (state_r == WAIT) && pselect && (cnt_r == {WAIT_CNT_W{1'b0}});
    assign we_s       = exec_s && write_r && in_range_s;

    apb_slave_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (pclk),
        .clr   (preset),
        .we    (we_s),
        .waddr (addr_r[IDX_W-1:0]),
        .wdata (wdata_r),
        .raddr (addr_r[IDX_W-1:0]),
        .rdata (rdata_s)
    );

    // Transfer FSM: latches the request at setup, counts wait states, then issues a one-cycle response.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_r   <= IDLE;
            cnt_r     <= {WAIT_CNT_W{1'b0}};
            addr_r    <= {WIDTH{1'b0}};
            wdata_r   <= {WIDTH{1'b0}};
            write_r   <= 1'b0;
            prdata_r  <= {WIDTH{1'b0}};
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    prdata_r  <= {WIDTH{1'b0}};
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                    // An access phase without a preceding setup is ignored.
                    if (pselect && !penable) begin
                        addr_r  <= paddr;
                        wdata_r <= pwdata;
                        write_r <= pwrite;
                        cnt_r   <= WAIT_LOAD;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (!pselect) begin
                        state_r <= IDLE;
                    end else if (cnt_r != {WAIT_CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_r   <= DONE;
                        pready_r  <= 1'b1;
                        pslverr_r <= !in_range_s;
                        prdata_r  <= (in_range_s && !write_r) ? rdata_s : {WIDTH{1'b0}};
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    prdata_r  <= {WIDTH{1'b0}};
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= {WAIT_CNT_W{1'b0}};
                    prdata_r  <= {WIDTH{1'b0}};
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                end
            endcase
        end
    end

    assign prdata  = prdata_r;
    assign pready  = pready_r;
    assign pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench: three completers (1, 0 and 3 wait states) against a per-instance memory model.
module tb_apb_slave_mem;
    import apb_slave_pkg::*;

    localparam int NI = 3;
    localparam int D  = 16;

    logic              pclk = 1'b0;
    logic              preset;
    logic [NI-1:0]     psel;
    logic              penable;
    logic              pwrite;
    logic [15:0]       paddr;
    logic [15:0]       pwdata;
    logic [15:0]       prdata_a [NI];
    logic [NI-1:0]     pready_a;
    logic [NI-1:0]     pslverr_a;

    int                waits [NI] = '{1, 0, 3};
    logic [15:0]       mem_m [NI][D];
    int                total = 0;
    int                bad   = 0;

    always #5 pclk = ~pclk;

    apb_slave_mem #(.WIDTH(16), .DEPTH(16), .WAIT_CYCLES(1)) u_w1 (
        .pclk(pclk), .preset(preset), .pselect(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[0]), .pready(pready_a[0]), .pslverr(pslverr_a[0]));
    apb_slave_mem #(.WIDTH(16), .DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
        .pclk(pclk), .preset(preset), .pselect(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[1]), .pready(pready_a[1]), .pslverr(pslverr_a[1]));
    apb_slave_mem #(.WIDTH(16), .DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
        .pclk(pclk), .preset(preset), .pselect(psel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[2]), .pready(pready_a[2]), .pslverr(pslverr_a[2]));

    // Reference: a register bank per instance, out-of-range accesses flag an error and never write.
    task automatic model_access(input int k, input logic wr, input logic [15:0] a, input logic [15:0] d,
                                output logic [15:0] erd, output logic eer);
        if (a < 16'(D)) begin
            eer = 1'b0;
            if (wr) begin
                mem_m[k][a] = d;
                erd = 16'h0000;
            end else begin
                erd = mem_m[k][a];
            end
        end else begin
            eer = 1'b1;
            erd = 16'h0000;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < D; i++)
                mem_m[k][i] = 16'h0000;
    endtask

    // Bus driver: starts at a negedge, returns first-pready cycle (setup = 0) or -1 on timeout.
    task automatic apb_xfer(input int k, input logic wr, input logic [15:0] a, input logic [15:0] d,
                            input logic scramble, output int lat, output logic [15:0] rd,
                            output logic er, output logic leak, output logic longp);
        lat = -1; rd = 16'h0000; er = 1'b0; leak = 1'b0; longp = 1'b0;
        psel = 3'b001 << k; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (pready_a[k] === 1'b1) begin
                lat = c; rd = prdata_a[k]; er = pslverr_a[k];
                break;
            end
            if (prdata_a[k] !== 16'h0000 || pslverr_a[k] !== 1'b0) leak = 1'b1;
            if (scramble) begin
                paddr = 16'($urandom); pwdata = 16'($urandom); pwrite = 1'($urandom);
            end
            @(negedge pclk);
        end
        @(negedge pclk);
        if (pready_a[k] !== 1'b0) longp = 1'b1;
        if (prdata_a[k] !== 16'h0000 || pslverr_a[k] !== 1'b0) leak = 1'b1;
        psel = 3'b000; penable = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0000; pwdata = 16'h0000;
        model_clear();
        @(negedge pclk);
        @(negedge pclk);
        total++; if (pready_a !== 3'b000) begin bad++; $display("FAIL reset_pready: got %b want 000", pready_a); end
        total++; if (pslverr_a !== 3'b000) begin bad++; $display("FAIL reset_pslverr: got %b want 000", pslverr_a); end
        for (int k = 0; k < NI; k++) begin
            total++; if (prdata_a[k] !== 16'h0000) begin bad++; $display("FAIL reset_prdata%0d: got %h want 0000", k, prdata_a[k]); end
        end
        preset = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_write_read_w1();
        int lat; logic [15:0] rd, erd; logic er, eer, lk, lp;
        model_access(0, 1'b1, 16'd3, 16'h00EE, erd, eer);
        apb_xfer(0, 1'b1, 16'd3, 16'h00EE, 1'b0, lat, rd, er, lk, lp);
        total++; if (lat !== 3) begin bad++; $display("FAIL wr3_latency: got %0d want 3", lat); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL wr3_pslverr: got %b want 0", er); end
        total++; if (lk || lp) begin bad++; $display("FAIL wr3_pulse: got leak=%b long=%b want 0 0", lk, lp); end
        model_access(0, 1'b0, 16'd3, 16'h0000, erd, eer);
        apb_xfer(0, 1'b0, 16'd3, 16'h0000, 1'b0, lat, rd, er, lk, lp);
        total++; if (rd !== erd) begin bad++; $display("FAIL rd3_data: got %h want %h", rd, erd); end
        total++; if (lat !== 3 || lk || lp) begin bad++; $display("FAIL rd3_timing: got lat=%0d leak=%b long=%b want 3 0 0", lat, lk, lp); end
    endtask

    task automatic test_read_w0();
        int lat; logic [15:0] rd, erd; logic er, eer, lk, lp;
        model_access(1, 1'b0, 16'd5, 16'h0000, erd, eer);
        apb_xfer(1, 1'b0, 16'd5, 16'h0000, 1'b0, lat, rd, er, lk, lp);
        total++; if (lat !== 2) begin bad++; $display("FAIL w0_latency: got %0d want 2", lat); end
        total++; if (rd !== erd || er !== eer) begin bad++; $display("FAIL w0_read5: got %h/%b want %h/%b", rd, er, erd, eer); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [15:0] rd, erd; logic er, eer, lk, lp;
        model_access(0, 1'b1, 16'd4, 16'h5A5A, erd, eer);
        apb_xfer(0, 1'b1, 16'd4, 16'h5A5A, 1'b0, lat, rd, er, lk, lp);
        model_access(0, 1'b1, 16'd20, 16'h1234, erd, eer);
        apb_xfer(0, 1'b1, 16'd20, 16'h1234, 1'b0, lat, rd, er, lk, lp);
        total++; if (er !== eer || rd !== erd) begin bad++; $display("FAIL oor_resp: got err=%b data=%h want %b %h", er, rd, eer, erd); end
        total++; if (lat !== 3 || lp) begin bad++; $display("FAIL oor_pulse: got lat=%0d long=%b want 3 0", lat, lp); end
        model_access(0, 1'b0, 16'd4, 16'h0000, erd, eer);
        apb_xfer(0, 1'b0, 16'd4, 16'h0000, 1'b0, lat, rd, er, lk, lp);
        total++; if (rd !== erd) begin bad++; $display("FAIL oor_alias4: got %h want %h", rd, erd); end
    endtask

    task automatic test_abort();
        int lat; logic [15:0] rd, erd; logic er, eer, lk, lp, seen;
        model_access(0, 1'b1, 16'd2, 16'h7777, erd, eer);
        apb_xfer(0, 1'b1, 16'd2, 16'h7777, 1'b0, lat, rd, er, lk, lp);
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 16'd2; pwdata = 16'h1111;
        @(negedge pclk);
        psel = 3'b000;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge pclk);
            if (pready_a[0] !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL abort_pready: got 1 want 0"); end
        model_access(0, 1'b0, 16'd2, 16'h0000, erd, eer);
        apb_xfer(0, 1'b0, 16'd2, 16'h0000, 1'b0, lat, rd, er, lk, lp);
        total++; if (rd !== erd) begin bad++; $display("FAIL abort_readback: got %h want %h", rd, erd); end
    endtask

    task automatic test_no_setup();
        int lat; logic [15:0] rd, erd; logic er, eer, lk, lp, seen;
        psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 16'd1; pwdata = 16'hDEAD;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge pclk);
            if (pready_a[0] !== 1'b0) seen = 1'b1;
        end
        psel = 3'b000; penable = 1'b0;
        @(negedge pclk);
        total++; if (seen) begin bad++; $display("FAIL nosetup_pready: got 1 want 0"); end
        model_access(0, 1'b0, 16'd1, 16'h0000, erd, eer);
        apb_xfer(0, 1'b0, 16'd1, 16'h0000, 1'b0, lat, rd, er, lk, lp);
        total++; if (rd !== erd || lat !== 3) begin bad++; $display("FAIL nosetup_readback: got %h lat=%0d want %h lat=3", rd, lat, erd); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] rd, erd; logic er, eer, lk, lp;
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 16'd7; pwdata = 16'hBEEF;
        @(negedge pclk);
        penable = 1'b1; preset = 1'b1;
        model_clear();
        @(negedge pclk);
        total++; if (pready_a[0] !== 1'b0 || pslverr_a[0] !== 1'b0 || prdata_a[0] !== 16'h0000) begin
            bad++; $display("FAIL rstmid_outputs: got %b %b %h want 0 0 0000", pready_a[0], pslverr_a[0], prdata_a[0]);
        end
        total++; if (u_w1.state_r !== IDLE) begin bad++; $display("FAIL rstmid_state: got %0d want %0d", u_w1.state_r, IDLE); end
        preset = 1'b0; psel = 3'b000; penable = 1'b0;
        @(negedge pclk);
        model_access(0, 1'b0, 16'd7, 16'h0000, erd, eer);
        apb_xfer(0, 1'b0, 16'd7, 16'h0000, 1'b0, lat, rd, er, lk, lp);
        total++; if (rd !== erd) begin bad++; $display("FAIL rstmid_read7: got %h want %h", rd, erd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] rd, erd; logic er, eer, lk, lp;
        for (int k = 0; k < NI; k += 2) begin
            for (int i = 0; i < 4; i++) begin
                model_access(k, 1'b1, 16'(i), 16'hA0 + 16'(i), erd, eer);
                apb_xfer(k, 1'b1, 16'(i), 16'hA0 + 16'(i), 1'b0, lat, rd, er, lk, lp);
                total++; if (lat !== waits[k] + 2 || lp || lk) begin
                    bad++; $display("FAIL b2b_wr%0d_%0d: got lat=%0d long=%b leak=%b want %0d 0 0", k, i, lat, lp, lk, waits[k] + 2);
                end
            end
            for (int i = 0; i < 4; i++) begin
                model_access(k, 1'b0, 16'(i), 16'h0000, erd, eer);
                apb_xfer(k, 1'b0, 16'(i), 16'h0000, 1'b0, lat, rd, er, lk, lp);
                total++; if (rd !== erd || lat !== waits[k] + 2 || lp) begin
                    bad++; $display("FAIL b2b_rd%0d_%0d: got %h lat=%0d want %h lat=%0d", k, i, rd, lat, erd, waits[k] + 2);
                end
            end
        end
    endtask

    task automatic test_random();
        int lat, k; logic [15:0] rd, erd, a, d; logic er, eer, lk, lp, wr;
        for (int n = 0; n < 80; n++) begin
            k  = int'($urandom_range(0, NI - 1));
            wr = 1'($urandom);
            a  = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            d  = 16'($urandom);
            model_access(k, wr, a, d, erd, eer);
            apb_xfer(k, wr, a, d, 1'b1, lat, rd, er, lk, lp);
            total++; if (rd !== erd || er !== eer || lat !== waits[k] + 2 || lk || lp) begin
                bad++; $display("FAIL rand_%0d: inst=%0d wr=%b a=%h got %h/%b lat=%0d leak=%b long=%b want %h/%b lat=%0d",
                                n, k, wr, a, rd, er, lat, lk, lp, erd, eer, waits[k] + 2);
            end
            if ($urandom_range(0, 3) == 0) @(negedge pclk);
        end
    endtask

    initial begin
        test_reset();
        test_write_read_w1();
        test_read_w0();
        test_out_of_range();
        test_abort();
        test_no_setup();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
